// File: rtl/alu_issue_pkg.sv
// Shared opcode/funct constants, FSM states and decode record for the
// ALU issue/commit front-end.
package alu_issue_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_COMMIT,
    ST_HALT
  } state_e;

  // What an instruction does at commit time
  typedef struct packed {
    logic writes_rd;
    logic writes_rt;
    logic writes_hilo;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_bne;
    logic traps_ovf;
    logic illegal;
  } dec_t;

  // Branch target: pc + 4 + (sign-extended word offset << 2), modulo 2^32
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [15:0] imm);
    return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/alu_issue_unit_decode.sv
// Combinational instruction classifier: maps an instruction word to the
// set of commit actions it requires.
module alu_issue_unit_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] ir_i,
  output dec_t        dec_o
);

  // Classify opcode and, for R-type, the funct field
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a field unassigned, which would otherwise infer a latch.
    dec_o = '0;
    case (ir_i[31:26])
      OP_RTYPE: begin
        case (ir_i[5:0])
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU:                  dec_o.writes_rd   = 1'b1;
          FN_ADD, FN_SUB: begin
            dec_o.writes_rd = 1'b1;
            dec_o.traps_ovf = 1'b1;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: dec_o.writes_hilo = 1'b1;
          default:                          dec_o.illegal     = 1'b1;
        endcase
      end
      OP_ADDI: begin
        dec_o.writes_rt = 1'b1;
        dec_o.traps_ovf = 1'b1;
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI:
        dec_o.writes_rt = 1'b1;
      OP_LW: begin
        dec_o.writes_rt = 1'b1;
        dec_o.is_lw     = 1'b1;
      end
      OP_SW:   dec_o.is_sw   = 1'b1;
      OP_BEQ:  dec_o.is_beq  = 1'b1;
      OP_BNE:  dec_o.is_bne  = 1'b1;
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue/commit front-end for a combinational MIPS ALU: fetches, reads
// operands, holds them for the ALU, samples its flags and commits.
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic [31:0] alu_instr,
  output logic [31:0] alu_rs,
  output logic [31:0] alu_rt,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic        wb_mem,
  output logic        hilo_en,
  output logic        mem_we,
  output logic [31:0] pc,
  output logic        ovf_trap,
  output logic        illegal,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, rs_q, rt_q;
  logic        zero_q, ovf_q;
  logic        ovf_trap_q, illegal_q;
  dec_t        dec;
  logic        in_commit;
  logic        branch_taken;
  logic        ovf_suppress;

  alu_issue_unit_decode u_decode (
    .ir_i  (ir_q),
    .dec_o (dec)
  );

  assign in_commit    = (state_q == ST_COMMIT);
  assign branch_taken = (dec.is_beq & zero_q) | (dec.is_bne & ~zero_q);
  assign ovf_suppress = dec.traps_ovf & ovf_q;

  // Next state and next PC; the PC only moves when leaving COMMIT
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  if (imem_ack) state_d = ST_DECODE;
      ST_DECODE: state_d = (ir_q == HALT_WORD) ? ST_HALT : ST_EXEC;
      ST_EXEC:   state_d = ST_COMMIT;
      ST_COMMIT: begin
        state_d = ST_FETCH;
        pc_d    = branch_taken ? branch_target(pc_q, ir_q[15:0]) : pc_q + 32'd4;
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and PC registers
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Instruction, operand and flag capture plus sticky exception flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ovf_trap_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      if (state_q == ST_FETCH && imem_ack) ir_q <= imem_rdata;
      if (state_q == ST_DECODE) begin
        rs_q <= rf_rdata1;
        rt_q <= rf_rdata2;
      end
      if (state_q == ST_EXEC) begin
        zero_q <= alu_zero;
        ovf_q  <= alu_overflow;
      end
      if (in_commit && ovf_suppress) ovf_trap_q <= 1'b1;
      if (in_commit && dec.illegal)  illegal_q  <= 1'b1;
    end
  end

  assign imem_req  = (state_q == ST_FETCH);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign rf_raddr1 = ir_q[25:21];
  assign rf_raddr2 = ir_q[20:16];
  assign alu_instr = ir_q;
  assign alu_rs    = rs_q;
  assign alu_rt    = rt_q;

  // Commit strobes; an overflowing add/sub/addi suppresses its write-back
  assign wb_en    = in_commit & (dec.writes_rd | dec.writes_rt) & ~ovf_suppress;
  assign wb_addr  = dec.writes_rd ? ir_q[15:11] : ir_q[20:16];
  assign wb_mem   = in_commit & dec.is_lw;
  assign hilo_en  = in_commit & dec.writes_hilo;
  assign mem_we   = in_commit & dec.is_sw;
  assign ovf_trap = ovf_trap_q;
  assign illegal  = illegal_q;
  assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: instruction memory, register file
// and ALU are modelled here; an ISA-level reference predicts commit effects.
module tb_alu_issue_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [5:0] R_LEGAL [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                          6'h18, 6'h19, 6'h1a, 6'h1b, 6'h20, 6'h21,
                                          6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27};
  localparam logic [5:0] I_LEGAL [9]  = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c,
                                          6'h0d, 6'h0e, 6'h23, 6'h2b};

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [31:0] alu_instr, alu_rs, alu_rt;
  logic        alu_zero, alu_overflow;
  logic        wb_en, wb_mem, hilo_en, mem_we;
  logic [4:0]  wb_addr;
  logic [31:0] pc;
  logic        ovf_trap, illegal, halted;

  logic [31:0] rf [32];

  int errors = 0;
  int checks = 0;

  // Reference architectural state
  logic [31:0] m_pc;
  logic        m_ovf, m_ill;

  // Strobes observed in the most recent COMMIT cycle
  logic        last_wb_en, last_wb_mem, last_hilo, last_mem_we;
  logic [4:0]  last_wb_addr;

  typedef struct packed {
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic        wb_mem;
    logic        hilo_en;
    logic        mem_we;
    logic        ovf;
    logic        ill;
    logic [31:0] next_pc;
  } exp_t;

  alu_issue_unit #(.RESET_PC(RESET_PC), .HALT_WORD(HALT_WORD)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .rf_raddr1    (rf_raddr1),
    .rf_raddr2    (rf_raddr2),
    .rf_rdata1    (rf_rdata1),
    .rf_rdata2    (rf_rdata2),
    .alu_instr    (alu_instr),
    .alu_rs       (alu_rs),
    .alu_rt       (alu_rt),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_mem       (wb_mem),
    .hilo_en      (hilo_en),
    .mem_we       (mem_we),
    .pc           (pc),
    .ovf_trap     (ovf_trap),
    .illegal      (illegal),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  // Environment ALU: adds or subtracts and always reports signed overflow,
  // even for the unsigned variants, so the unit must decide what traps.
  logic [31:0] alu_b, alu_res;
  logic        alu_sub;
  always_comb begin
    alu_b   = alu_rt;
    alu_sub = 1'b0;
    if (alu_instr[31:26] == 6'h08 || alu_instr[31:26] == 6'h09)
      alu_b = {{16{alu_instr[15]}}, alu_instr[15:0]};
    if (alu_instr[31:26] == 6'h04 || alu_instr[31:26] == 6'h05) alu_sub = 1'b1;
    if (alu_instr[31:26] == 6'h00 && (alu_instr[5:0] == 6'h22 || alu_instr[5:0] == 6'h23))
      alu_sub = 1'b1;
    alu_res      = alu_sub ? alu_rs - alu_b : alu_rs + alu_b;
    alu_zero     = (alu_res == 32'd0);
    alu_overflow = alu_sub ? (alu_rs[31] != alu_b[31]) && (alu_res[31] != alu_rs[31])
                           : (alu_rs[31] == alu_b[31]) && (alu_res[31] != alu_rs[31]);
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic bit overflows(input longint v);
    return (v > 64'sd2147483647) || (v < -64'sd2147483648);
  endfunction

  // ISA-level reference: what one instruction does given its operand values
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] cur_pc);
    exp_t   e;
    longint sa, sb, sim;
    e         = '0;
    e.next_pc = cur_pc + 32'd4;
    sa        = longint'($signed(a));
    sb        = longint'($signed(b));
    sim       = longint'($signed(w[15:0]));
    case (w[31:26])
      6'h00: begin
        case (w[5:0])
          6'h20: if (overflows(sa + sb)) e.ovf = 1'b1; else begin e.wb_en = 1'b1; e.wb_addr = w[15:11]; end
          6'h22: if (overflows(sa - sb)) e.ovf = 1'b1; else begin e.wb_en = 1'b1; e.wb_addr = w[15:11]; end
          6'h18, 6'h19, 6'h1a, 6'h1b: e.hilo_en = 1'b1;
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: begin
            e.wb_en   = 1'b1;
            e.wb_addr = w[15:11];
          end
          default: e.ill = 1'b1;
        endcase
      end
      6'h08: if (overflows(sa + sim)) e.ovf = 1'b1; else begin e.wb_en = 1'b1; e.wb_addr = w[20:16]; end
      6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: begin
        e.wb_en   = 1'b1;
        e.wb_addr = w[20:16];
      end
      6'h23: begin
        e.wb_en   = 1'b1;
        e.wb_mem  = 1'b1;
        e.wb_addr = w[20:16];
      end
      6'h2b: e.mem_we = 1'b1;
      6'h04: if (a == b) e.next_pc = 32'(longint'(cur_pc) + 64'sd4 + sim * 4);
      6'h05: if (a != b) e.next_pc = 32'(longint'(cur_pc) + 64'sd4 + sim * 4);
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic do_reset();
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    m_pc  = RESET_PC;
    m_ovf = 1'b0;
    m_ill = 1'b0;
  endtask

  // Wait for the fetch request (bounded); returns 1 if it arrived
  task automatic wait_req(output bit ok);
    int guard = 0;
    while (imem_req !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    ok = (imem_req === 1'b1);
    if (!ok) begin
      errors++;
      $display("FAIL fetch_req: imem_req=%b after %0d cycles, required 1", imem_req, guard);
    end
  endtask

  // Issue one instruction with nwait ack-delay cycles and check it end to end
  task automatic run_one(input logic [31:0] word, input int nwait);
    exp_t        e;
    logic [31:0] a, b;
    int          k, nstb;
    bit          got, ok;
    logic        any_exp;
    wait_req(ok);
    if (!ok) return;
    checks++;
    if (imem_addr !== m_pc) begin
      errors++;
      $display("FAIL fetch_addr: imem_addr=%h, required %h", imem_addr, m_pc);
    end
    for (int i = 0; i < nwait; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
        errors++;
        $display("FAIL wait_hold: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, m_pc);
      end
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    a          = rf[word[25:21]];
    b          = rf[word[20:16]];
    e          = model(word, a, b, m_pc);
    any_exp    = e.wb_en | e.wb_mem | e.hilo_en | e.mem_we;
    k = 0; nstb = 0; got = 0;
    while (!got && k < 10) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        checks++;
        if (rf_raddr1 !== word[25:21] || rf_raddr2 !== word[20:16]) begin
          errors++;
          $display("FAIL rf_addr: raddr1=%0d raddr2=%0d, required %0d %0d",
                   rf_raddr1, rf_raddr2, word[25:21], word[20:16]);
        end
      end
      if (k == 2 || k == 3) begin
        checks++;
        if (alu_instr !== word || alu_rs !== a || alu_rt !== b) begin
          errors++;
          $display("FAIL alu_operands: instr=%h rs=%h rt=%h, required %h %h %h",
                   alu_instr, alu_rs, alu_rt, word, a, b);
        end
      end
      if ((wb_en | wb_mem | hilo_en | mem_we) !== 1'b0) nstb++;
      if (k == 3) begin
        last_wb_en   = wb_en;
        last_wb_mem  = wb_mem;
        last_hilo    = hilo_en;
        last_mem_we  = mem_we;
        last_wb_addr = wb_addr;
        checks++;
        if ({wb_en, wb_mem, hilo_en, mem_we} !== {e.wb_en, e.wb_mem, e.hilo_en, e.mem_we}) begin
          errors++;
          $display("FAIL commit_strobes %h: wb_en/wb_mem/hilo/we=%b%b%b%b, required %b%b%b%b",
                   word, wb_en, wb_mem, hilo_en, mem_we, e.wb_en, e.wb_mem, e.hilo_en, e.mem_we);
        end
        if (e.wb_en) begin
          checks++;
          if (wb_addr !== e.wb_addr) begin
            errors++;
            $display("FAIL wb_addr %h: got %0d, required %0d", word, wb_addr, e.wb_addr);
          end
        end
      end
      if (imem_req === 1'b1) got = 1;
    end
    checks++;
    if (!got || k != 4) begin
      errors++;
      $display("FAIL cycle_count %h: next fetch after %0d cycles (seen=%0d), required 4", word, k, got);
    end
    checks++;
    if (nstb != (any_exp ? 1 : 0)) begin
      errors++;
      $display("FAIL strobe_cycles %h: %0d strobe cycles, required %0d", word, nstb, any_exp ? 1 : 0);
    end
    m_pc  = e.next_pc;
    m_ovf = m_ovf | e.ovf;
    m_ill = m_ill | e.ill;
    checks++;
    if (pc !== m_pc) begin
      errors++;
      $display("FAIL next_pc %h: pc=%h, required %h", word, pc, m_pc);
    end
    checks++;
    if (ovf_trap !== m_ovf || illegal !== m_ill) begin
      errors++;
      $display("FAIL sticky %h: ovf_trap=%b illegal=%b, required %b %b",
               word, ovf_trap, illegal, m_ovf, m_ill);
    end
  endtask

  task automatic check_pc(input string name, input logic [31:0] want);
    checks++;
    if (pc !== want) begin
      errors++;
      $display("FAIL %s: pc=%h, required %h", name, pc, want);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, got, want);
    end
  endtask

  task automatic goto_0x10();
    do_reset();
    repeat (4) run_one(rtype(5'd0, 5'd0, 5'd0, 6'h21), 0);
    check_pc("reach_0x10", 32'h10);
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    @(negedge clk);
    checks++;
    if ({imem_req, wb_en, wb_mem, hilo_en, mem_we, ovf_trap, illegal, halted} !== 8'd0 ||
        pc !== RESET_PC || alu_instr !== 32'd0 || alu_rs !== 32'd0 || alu_rt !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: req=%b wb=%b pc=%h instr=%h rs=%h rt=%h ovf=%b ill=%b halt=%b",
               imem_req, wb_en, pc, alu_instr, alu_rs, alu_rt, ovf_trap, illegal, halted);
    end
    do_reset();
  endtask

  task automatic test_addi();
    run_one(32'h2001_0005, 0);
    check_bit("addi_wb_en", last_wb_en, 1'b1);
    checks++;
    if (last_wb_addr !== 5'd1) begin
      errors++;
      $display("FAIL addi_wb_addr: got %0d, required 1", last_wb_addr);
    end
    check_pc("addi_pc", 32'h4);
  endtask

  task automatic test_branches();
    rf[1] = 32'h0000_1234;
    rf[2] = 32'h0000_1234;
    rf[3] = 32'h0000_5678;
    goto_0x10();
    run_one(itype(6'h04, 5'd1, 5'd2, 16'h0003), 0);
    check_pc("beq_taken", 32'h20);
    check_bit("beq_no_wb", last_wb_en | last_hilo | last_mem_we, 1'b0);
    goto_0x10();
    run_one(itype(6'h05, 5'd1, 5'd2, 16'h0003), 0);
    check_pc("bne_not_taken", 32'h14);
    goto_0x10();
    run_one(itype(6'h05, 5'd1, 5'd3, 16'hFFFF), 0);
    check_pc("bne_self_loop", 32'h10);
    // Backward branch from 0 wraps to the top of memory, then wraps back
    do_reset();
    run_one(itype(6'h05, 5'd1, 5'd3, 16'hFFFE), 0);
    check_pc("pc_wrap_down", 32'hFFFF_FFFC);
    run_one(rtype(5'd0, 5'd0, 5'd0, 6'h21), 0);
    check_pc("pc_wrap_up", 32'h0);
  endtask

  task automatic test_overflow();
    rf[4] = 32'h7FFF_FFFF;
    rf[5] = 32'h0000_0001;
    rf[7] = 32'h8000_0000;
    do_reset();
    run_one(rtype(5'd4, 5'd5, 5'd6, 6'h20), 0);
    check_bit("add_ovf_no_wb", last_wb_en, 1'b0);
    check_bit("add_ovf_trap", ovf_trap, 1'b1);
    do_reset();
    run_one(rtype(5'd4, 5'd5, 5'd6, 6'h21), 0);
    check_bit("addu_wb", last_wb_en, 1'b1);
    check_bit("addu_no_trap", ovf_trap, 1'b0);
    run_one(itype(6'h09, 5'd4, 5'd9, 16'h0001), 0);
    check_bit("addiu_no_trap", ovf_trap, 1'b0);
    run_one(rtype(5'd7, 5'd5, 5'd8, 6'h22), 0);
    check_bit("sub_ovf_trap", ovf_trap, 1'b1);
    run_one(itype(6'h08, 5'd4, 5'd9, 16'h0001), 0);
    check_bit("addi_ovf_no_wb", last_wb_en, 1'b0);
  endtask

  task automatic test_wait_and_units();
    do_reset();
    run_one(32'h2001_0005, 3);
    check_pc("wait_pc", 32'h4);
    run_one(rtype(5'd1, 5'd2, 5'd0, 6'h18), 1);
    check_bit("mult_hilo", last_hilo, 1'b1);
    check_bit("mult_no_wb", last_wb_en, 1'b0);
    run_one(itype(6'h2b, 5'd1, 5'd2, 16'h0004), 0);
    check_bit("sw_mem_we", last_mem_we, 1'b1);
    run_one(itype(6'h23, 5'd1, 5'd2, 16'h0008), 2);
    check_bit("lw_wb_mem", last_wb_mem, 1'b1);
    run_one(rtype(5'd1, 5'd2, 5'd0, 6'h25), 0);
    check_bit("wb_to_r0", last_wb_en, 1'b1);
  endtask

  task automatic test_illegal();
    do_reset();
    run_one(itype(6'h3F, 5'd1, 5'd2, 16'h1234), 0);
    check_bit("illegal_opcode", illegal, 1'b1);
    check_pc("illegal_pc", 32'h4);
    do_reset();
    run_one(rtype(5'd1, 5'd2, 5'd3, 6'h01), 0);
    check_bit("illegal_funct", illegal, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [4:0]  rs, rt, rd;
    int          sel;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      for (int r = 1; r < 32; r++) rf[r] = $urandom;
      rs  = 5'($urandom);
      rt  = 5'($urandom);
      rd  = 5'($urandom);
      sel = $urandom_range(0, 9);
      if (sel <= 3)      w = rtype(rs, rt, rd, R_LEGAL[$urandom_range(0, 17)]);
      else if (sel <= 6) w = itype(I_LEGAL[$urandom_range(0, 8)], rs, rt, 16'($urandom));
      else if (sel <= 8) w = itype(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05, rs,
                                   ($urandom_range(0, 1) == 0) ? rs : rt, 16'($urandom));
      else               w = itype(6'h3F, rs, rt, 16'($urandom_range(0, 16'hFFFE)));
      run_one(w, $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid_exec();
    bit ok;
    do_reset();
    run_one(rtype(5'd0, 5'd0, 5'd0, 6'h21), 0);
    rf[1] = 32'h0000_0011;
    wait_req(ok);
    if (!ok) return;
    imem_ack   = 1'b1;
    imem_rdata = itype(6'h09, 5'd1, 5'd2, 16'h0007);
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    // Unit is now in EXEC: pull reset mid-instruction
    rst = 1'b1;
    #1;
    checks++;
    if ({imem_req, wb_en, wb_mem, hilo_en, mem_we, ovf_trap, illegal, halted} !== 8'd0 ||
        pc !== RESET_PC || alu_instr !== 32'd0 || alu_rs !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_exec: req=%b wb=%b pc=%h instr=%h rs=%h",
               imem_req, wb_en, pc, alu_instr, alu_rs);
    end
    @(negedge clk);
    check_bit("reset_no_commit", wb_en | wb_mem | hilo_en | mem_we, 1'b0);
    rst   = 1'b0;
    m_pc  = RESET_PC;
    m_ovf = 1'b0;
    m_ill = 1'b0;
    run_one(rtype(5'd1, 5'd1, 5'd3, 6'h24), 0);
    check_pc("refetch_after_reset", RESET_PC + 32'd4);
  endtask

  task automatic test_halt();
    bit ok;
    wait_req(ok);
    if (!ok) return;
    imem_ack   = 1'b1;
    imem_rdata = HALT_WORD;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h2001_0005;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || (wb_en | hilo_en | mem_we) !== 1'b0) begin
        errors++;
        $display("FAIL halt_quiet cycle %0d: req=%b wb=%b hilo=%b we=%b, required all 0",
                 c, imem_req, wb_en, hilo_en, mem_we);
      end
      imem_ack = 1'($urandom_range(0, 1));
    end
    imem_ack = 1'b0;
    check_bit("halted", halted, 1'b1);
    check_pc("halt_pc_frozen", m_pc);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = 32'd0;
    m_pc = RESET_PC; m_ovf = 1'b0; m_ill = 1'b0;
    last_wb_en = 1'b0; last_wb_mem = 1'b0; last_hilo = 1'b0; last_mem_we = 1'b0;
    last_wb_addr = 5'd0;
    test_reset();
    test_addi();
    test_branches();
    test_overflow();
    test_wait_and_units();
    test_illegal();
    test_random();
    test_reset_mid_exec();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
